// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared constants and reader state type for the 16x2 BRAM reader
package bram_pkg;

    localparam int BRAM_ADDR_W = 4;
    localparam int BRAM_DATA_W = 2;
    localparam int BRAM_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry synchronous FIFO carrying a data word and a last flag
module stream_fifo2 #(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);

    logic [DATA_W:0] entries [2];
    logic            rd_ptr;
    logic            wr_ptr;

    // Push on a full FIFO is only legal together with a pop; the slot being
    // overwritten is the one leaving at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[wr_ptr] <= {push_last, push_data};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = entries[rd_ptr][DATA_W-1:0];
    assign head_last = entries[rd_ptr][DATA_W];

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - sweeps a wrapping BRAM address range onto a valid/ready stream
module bram_stream_reader
    import bram_pkg::*;
#(
    parameter int ADDR_W    = BRAM_ADDR_W,
    parameter int DATA_W    = BRAM_DATA_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len_m1,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    reader_state_t     state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   beat_left;
    logic              inflight;
    logic              inflight_last;

    logic [1:0]        occ;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic              pop;
    logic [2:0]        pending;
    logic              credit_ok;
    logic              issue;
    logic              issue_last;

    assign pop       = out_valid & out_ready;
    // Buffered words plus the read still in flight must leave a free slot,
    // counting the slot a same-cycle pop releases.
    assign pending   = {1'b0, occ} + {2'b00, inflight};
    assign credit_ok = pending < (3'(BUF_DEPTH) + {2'b00, pop});

    assign issue      = (state == READ) && (issue_left != '0) && credit_ok;
    assign issue_last = (issue_left == (ADDR_W+1)'(1));
    assign mem_en     = issue;
    assign mem_addr   = issue ? cur_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            cur_addr      <= '0;
            issue_left    <= '0;
            beat_left     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue & issue_last;
            done          <= 1'b0;
            if (pop && beat_left != '0) begin
                beat_left <= beat_left - (ADDR_W+1)'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr   <= base_addr;
                        issue_left <= {1'b0, len_m1} + (ADDR_W+1)'(1);
                        beat_left  <= {1'b0, len_m1} + (ADDR_W+1)'(1);
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        cur_addr   <= cur_addr + ADDR_W'(1);
                        issue_left <= issue_left - (ADDR_W+1)'(1);
                        if (issue_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && beat_left == (ADDR_W+1)'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    stream_fifo2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (mem_q),
        .push_last (inflight_last),
        .pop       (pop),
        .count     (occ),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? head_data : '0;
    assign out_last  = out_valid & head_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed self-checking bench for bram_stream_reader
module tb_bram_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] base_addr;
    logic [3:0] len_m1;
    logic       busy;
    logic       done;
    logic       mem_en;
    logic [3:0] mem_addr;
    logic [1:0] mem_q = 2'b00;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic       out_last;

    logic [1:0] mem [16];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int exp_addr[$];
    int exp_data[$];
    bit exp_last[$];
    int rx[$];
    int outstanding = 0;
    int cmd_cycle = 0;
    bit fv_pend = 0;
    bit fe_pend = 0;
    int en_cmd = 0;
    int done_cnt = 0;
    int done_cycle = -1;
    bit last_prev = 0;
    bit stalled_prev = 0;
    int sd = 0;
    bit sl = 0;

    bram_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len_m1    (len_m1),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_q <= mem[mem_addr];
    end

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int b, input int l);
        for (int i = 0; i <= l; i++) begin
            exp_addr.push_back((b + i) % 16);
            exp_data.push_back(int'(mem[(b + i) % 16]));
            exp_last.push_back(i == l);
        end
        start     = 1'b1;
        base_addr = 4'(b);
        len_m1    = 4'(l);
        cmd_cycle = cyc;
        fv_pend   = 1'b1;
        fe_pend   = 1'b1;
        en_cmd    = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int max);
        int k = 0;
        while (rx.size() < n && k < max) begin
            step();
            k++;
        end
        chk(rx.size() >= n, "wait_rx_timeout", rx.size(), n);
    endtask

    task automatic wait_done(input int target, input int max);
        int k = 0;
        while (done_cnt < target && k < max) begin
            step();
            k++;
        end
        chk(done_cnt >= target, "wait_done_timeout", done_cnt, target);
    endtask

    task automatic chk_all_zero(input string name);
        chk({busy, done, mem_en, out_valid, out_last} == 5'b0, name, int'({busy, done, mem_en, out_valid, out_last}), 0);
        chk(mem_addr == 4'd0 && out_data == 2'd0, name, int'({mem_addr, out_data}), 0);
    endtask

    // Reference model: every read address, beat and done pulse is compared
    // against queues built from the command and the memory contents.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
            last_prev    = 1'b0;
        end else begin
            chk(done == last_prev, "done_pulse", int'(done), int'(last_prev));
            if (done) begin
                done_cnt++;
                done_cycle = cyc;
                chk(!busy, "busy_at_done", int'(busy), 0);
            end
            last_prev = 1'b0;
            if (mem_en) begin
                if (fe_pend) begin
                    chk(cyc == cmd_cycle + 1, "first_en_latency", cyc - cmd_cycle, 1);
                    fe_pend = 1'b0;
                end
                if (exp_addr.size() == 0) begin
                    chk(1'b0, "spurious_read", int'(mem_addr), -1);
                end else begin
                    chk(int'(mem_addr) == exp_addr[0], "read_addr", int'(mem_addr), exp_addr[0]);
                    void'(exp_addr.pop_front());
                end
                outstanding++;
                en_cmd++;
            end
            if (stalled_prev) begin
                chk(out_valid && int'(out_data) == sd && out_last == sl, "stall_hold",
                    int'({out_valid, out_last, out_data}), int'({1'b1, sl, 2'(sd)}));
            end
            if (out_valid && fv_pend) begin
                chk(cyc == cmd_cycle + 3, "first_valid_latency", cyc - cmd_cycle, 3);
                fv_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    chk(1'b0, "spurious_beat", int'(out_data), -1);
                end else begin
                    chk(int'(out_data) == exp_data[0], "beat_data", int'(out_data), exp_data[0]);
                    chk(out_last == exp_last[0], "beat_last", int'(out_last), int'(exp_last[0]));
                    last_prev = exp_last[0];
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                end
                rx.push_back(int'(out_data));
                outstanding--;
            end
            chk(outstanding <= 2, "occupancy", outstanding, 2);
            stalled_prev = out_valid && !out_ready;
            sd = int'(out_data);
            sl = out_last;
        end
    end

    initial begin
        int c0;
        int d0;
        int nrx;
        int nen;

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = 4'd0;
        len_m1    = 4'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);
        step();
        chk_all_zero("reset_outputs");
        step();
        rst_n = 1'b1;
        step();
        chk_all_zero("idle_after_reset");

        // single word
        mem[5] = 2'b10;
        rx.delete();
        d0 = done_cnt;
        cmd(5, 0);
        c0 = cmd_cycle;
        wait_done(d0 + 1, 50);
        chk(done_cycle == c0 + 4, "single_done_cycle", done_cycle - c0, 4);
        chk(rx.size() == 1 && rx[0] == 2, "single_beat", rx.size() > 0 ? rx[0] : -1, 2);
        chk(en_cmd == 1, "single_mem_en_count", en_cmd, 1);
        mem[5] = 2'd1;

        // full sweep, ready high
        rx.delete();
        d0 = done_cnt;
        cmd(0, 15);
        c0 = cmd_cycle;
        wait_done(d0 + 1, 60);
        chk(done_cycle == c0 + 19, "sweep_done_cycle", done_cycle - c0, 19);
        chk(rx.size() == 16, "sweep_beat_count", rx.size(), 16);
        chk(rx.size() == 16 && rx[4] == 0 && rx[15] == 3, "sweep_literal", rx.size() == 16 ? rx[15] : -1, 3);

        // wrap
        rx.delete();
        d0 = done_cnt;
        cmd(14, 3);
        wait_done(d0 + 1, 40);
        chk(rx.size() == 4, "wrap_count", rx.size(), 4);
        chk(rx.size() == 4 && rx[0] == 2 && rx[1] == 3 && rx[2] == 0 && rx[3] == 1,
            "wrap_literal", rx.size() == 4 ? rx[2] : -1, 0);

        // backpressure
        rx.delete();
        d0 = done_cnt;
        cmd(0, 15);
        wait_rx(3, 40);
        out_ready = 1'b0;
        repeat (5) step();
        chk(en_cmd == 5, "stall_issue_limit", en_cmd, 5);
        chk(rx.size() == 3, "stall_no_beats", rx.size(), 3);
        out_ready = 1'b1;
        wait_done(d0 + 1, 60);
        chk(rx.size() == 16, "bp_beat_count", rx.size(), 16);

        // start while busy, then restart in the done cycle
        rx.delete();
        d0 = done_cnt;
        cmd(0, 15);
        c0 = cmd_cycle;
        repeat (5) step();
        start     = 1'b1;
        base_addr = 4'd9;
        len_m1    = 4'd2;
        step();
        start = 1'b0;
        while (cyc < c0 + 19) step();
        cmd(3, 1);
        wait_done(d0 + 2, 40);
        chk(done_cnt == d0 + 2, "restart_done_count", done_cnt, d0 + 2);
        chk(rx.size() == 18 && rx[16] == 3 && rx[17] == 0, "restart_literal", rx.size(), 18);

        // reset mid-stream
        rx.delete();
        cmd(0, 15);
        wait_rx(4, 40);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midstream_reset");
        exp_addr.delete();
        exp_data.delete();
        exp_last.delete();
        outstanding = 0;
        fv_pend = 1'b0;
        fe_pend = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        nrx = rx.size();
        nen = en_cmd;
        repeat (5) step();
        chk(rx.size() == nrx && en_cmd == nen, "quiet_after_reset", rx.size() - nrx + en_cmd - nen, 0);
        rx.delete();
        d0 = done_cnt;
        cmd(7, 2);
        wait_done(d0 + 1, 40);
        chk(rx.size() == 3 && rx[0] == 3 && rx[1] == 0 && rx[2] == 1, "post_reset_literal",
            rx.size() == 3 ? rx[0] : -1, 3);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
